// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg: shared FSM state encoding and I2C bus constants.
// Rev 1.0
// ============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_BYTE   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_BYTE   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  localparam int   I2C_BYTE_BITS = 8;
  localparam logic ACK           = 1'b0;
  localparam logic NACK          = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_if.sv
`default_nettype none
// ============================================================================
// i2c_if: application-side byte handshake of the I2C target.
// Rev 1.0
// ============================================================================
interface i2c_if;
  import i2c_pkg::*;

  logic [I2C_BYTE_BITS-1:0] rx_data;
  logic                     rx_valid;
  logic                     tx_req;
  logic [I2C_BYTE_BITS-1:0] tx_data;
  logic                     rw_out;
  logic                     addressed;
  logic                     start_det;
  logic                     stop_det;

  modport slave (
    output rx_data, rx_valid, tx_req, rw_out, addressed, start_det, stop_det,
    input  tx_data
  );

  modport master (
    input  rx_data, rx_valid, tx_req, rw_out, addressed, start_det, stop_det,
    output tx_data
  );

endinterface
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// i2c_line_filter: 2-flop synchronizer, glitch filter and edge detector.
// Rev 1.0
// ============================================================================
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync1;
  logic             sync2;
  logic             filt;
  logic             filt_q;
  logic [CNT_W-1:0] cnt;

  // Idle bus level is high, so everything resets to 1 to avoid a fake edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      filt   <= 1'b1;
      filt_q <= 1'b1;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1 <= line_in;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      filt_q <= filt;
      rise   <= filt & ~filt_q;
      fall   <= ~filt & filt_q;
    end
  end

  assign level = filt_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// i2c_target: single-address I2C target, no clock stretching, open-drain SDA.
// Rev 1.0
// ============================================================================
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS    = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   i2c_scl,
  inout  wire    i2c_sda,
  i2c_if.slave   bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clock   (clock),
    .reset   (reset),
    .line_in (i2c_scl),
    .level   (scl_lvl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clock   (clock),
    .reset   (reset),
    .line_in (i2c_sda),
    .level   (sda_lvl),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  state_t                   state;
  logic [2:0]               bit_cnt;
  logic [I2C_BYTE_BITS-1:0] shreg;
  logic                     sda_oe;
  logic                     ack_drv;
  logic                     rd_load;
  logic [I2C_BYTE_BITS-1:0] rx_data;
  logic                     rx_valid, tx_req, rw_out, addressed, start_det, stop_det;

  logic start_cond, stop_cond, last_bit;
  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;
  assign last_bit   = (bit_cnt == 3'(I2C_BYTE_BITS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= '0;
      sda_oe    <= 1'b0;
      ack_drv   <= 1'b0;
      rd_load   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      rw_out    <= 1'b0;
      addressed <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (start_cond) begin
        state     <= ST_ADDR;
        bit_cnt   <= 3'd0;
        sda_oe    <= 1'b0;
        ack_drv   <= 1'b0;
        rd_load   <= 1'b0;
        addressed <= 1'b0;
        start_det <= 1'b1;
      end else if (stop_cond) begin
        state     <= ST_IDLE;
        sda_oe    <= 1'b0;
        ack_drv   <= 1'b0;
        rd_load   <= 1'b0;
        addressed <= 1'b0;
        stop_det  <= 1'b1;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_lvl};
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              if (shreg[6:0] == ADDRESS) begin
                state     <= ST_ADDR_ACK;
                addressed <= 1'b1;
                rw_out    <= sda_lvl;
                tx_req    <= sda_lvl;
                ack_drv   <= 1'b0;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          // First falling edge starts the ACK low, the second one ends it.
          ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
            if (!ack_drv) begin
              ack_drv <= 1'b1;
              sda_oe  <= 1'b1;
              if (state == ST_ADDR_ACK && rw_out) shreg <= bus.tx_data;
            end else begin
              ack_drv <= 1'b0;
              bit_cnt <= 3'd0;
              if (state == ST_ADDR_ACK && rw_out) begin
                state  <= ST_RD_BYTE;
                sda_oe <= (shreg[7] != NACK);
              end else begin
                state  <= ST_WR_BYTE;
                sda_oe <= 1'b0;
              end
            end
          end
          ST_WR_BYTE: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_lvl};
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              rx_data  <= {shreg[6:0], sda_lvl};
              rx_valid <= 1'b1;
              ack_drv  <= 1'b0;
              state    <= ST_WR_ACK;
            end
          end
          ST_RD_BYTE: if (scl_fall) begin
            if (rd_load) begin
              rd_load <= 1'b0;
              shreg   <= bus.tx_data;
              sda_oe  <= (bus.tx_data[7] != NACK);
              bit_cnt <= 3'd0;
            end else if (last_bit) begin
              sda_oe <= 1'b0;
              state  <= ST_RD_ACK;
            end else begin
              shreg   <= {shreg[6:0], 1'b0};
              sda_oe  <= (shreg[6] != NACK);
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          ST_RD_ACK: if (scl_rise) begin
            if (sda_lvl == ACK) begin
              tx_req  <= 1'b1;
              rd_load <= 1'b1;
              state   <= ST_RD_BYTE;
            end else begin
              addressed <= 1'b0;
              state     <= ST_WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign i2c_sda       = sda_oe ? 1'b0 : 1'bz;
  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.tx_req    = tx_req;
  assign bus.rw_out    = rw_out;
  assign bus.addressed = addressed;
  assign bus.start_det = start_det;
  assign bus.stop_det  = stop_det;

endmodule
`default_nettype wire

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Single-address I2C target (slave), the responder for the team's I2C controller on the same two-wire bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address and ACKs it. Delivers written bytes as one-cycle strobes and fetches read bytes through a request/data handshake.
- No clock stretching: SCL is input-only. SDA is open-drain.

Parameters:
- ADDRESS, 7'h50, own 7-bit target address.
- FILTER_LEN, 3, consecutive equal samples needed before a filtered line changes level (glitch rejection).

Ports:
- clock  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  synchronous, active-high reset.
- i2c_scl  input  1  bus clock, sampled only.
- i2c_sda  inout  1  bus data, open-drain: driven 0 or high-Z, never driven 1.
- rx_data  output  8  last byte written by the controller, MSB first on the wire.
- rx_valid  output  1  one-cycle pulse; rx_data is valid in that cycle.
- tx_req  output  1  one-cycle pulse requesting the next read byte.
- tx_data  input  8  read byte; captured at the first SCL falling edge after tx_req.
- rw_out  output  1  R/W bit of the current addressed transfer (1 = read).
- addressed  output  1  high from address ACK until STOP, repeated START or NACK.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: SDA released (high-Z), all outputs 0, state IDLE, bit counter 0.
- Reset asserted mid-transfer: SDA is released on the next clock edge, including during an ACK or a data bit.

Line conditioning:
- Each line passes through a 2-flop synchronizer, then the FILTER_LEN glitch filter, then a one-cycle rise/fall edge detector.
- Pin-to-event latency is 2 + FILTER_LEN + 1 cycles.

Bus conditions:
- START = filtered SDA falls while filtered SCL is high. STOP = filtered SDA rises while SCL is high.
- Both are recognised in every state, and outrank any bit event in the same cycle.
- START in any state: go to ADDR, clear the bit counter, release SDA, pulse start_det.
- STOP in any state: go to IDLE, release SDA, pulse stop_det.

Bit timing:
- Data is sampled on SCL rising edges.
- SDA changes only on SCL falling edges.

States:
- IDLE: wait for START.
- ADDR: shift 8 bits (7 address bits + R/W). After the 8th rising edge: on match go to ADDR_ACK, else go to WAIT_STOP.
- ADDR_ACK: drive SDA low from the next SCL falling edge to the following falling edge. Assert addressed and latch rw_out. At the end: if write go to WR_BYTE; if read go to RD_BYTE, with tx_req pulsed on entry to ADDR_ACK.
- WR_BYTE: shift 8 bits. The cycle after the 8th rising edge: rx_data updated and rx_valid pulsed. Then go to WR_ACK.
- WR_ACK: ACK for one SCL period, same window as ADDR_ACK. Then return to WR_BYTE. The target always ACKs written bytes.
- RD_BYTE: at the falling edge that opens the byte, load tx_data into the shift register and drive its MSB. Drive each following bit on the next falling edge (a 1 means released). After the 8th bit's falling edge, release SDA and go to RD_ACK.
- RD_ACK: sample the controller's ACK on the SCL rising edge. ACK (0): pulse tx_req, go to RD_BYTE. NACK (1): clear addressed, go to WAIT_STOP.
- WAIT_STOP: SDA released; ignore bits until START or STOP.

Boundaries:
- Address mismatch: SDA is never driven.
- General call (0x00) is not matched.
- tx_data must be stable from tx_req until the next SCL falling edge; it is not checked.

Decomposition:
- Package i2c_pkg: state enum, I2C_BYTE_BITS = 8, ACK = 1'b0, NACK = 1'b1.
- Sub-module i2c_line_filter (sync + glitch filter + edge detect, parameter FILTER_LEN): instantiated once for SCL and once for SDA.
- Top level holds the FSM, the 3-bit bit counter, the shift register and the open-drain SDA output.

Test Plan:
- Write to 0x50 with bytes 0xA5, 0x3C, then STOP -> target ACKs the address and both bytes; rx_valid pulses twice with rx_data = 0xA5, then 0x3C; stop_det pulses once; addressed falls.
- Write to 0x51 -> SDA never driven, controller sees NACK; no rx_valid, addressed stays 0; STOP returns the FSM to IDLE.
- Read from 0x50, tx_data = 0x96 then 0x01, controller ACKs then NACKs -> SDA carries 1001_0110 then 0000_0001; tx_req pulses twice; SDA released after the NACK; rw_out = 1.
- Write 0x50 plus one byte 0x10, then repeated START and read 0x50 -> start_det pulses twice; rx_data = 0x10; rw_out changes 0 -> 1; first tx_req pulses on the second address ACK.
- 2-cycle SCL glitch during a data bit with FILTER_LEN = 3 -> no extra bit shifted; the byte still received correctly.
- reset asserted while the target drives the ACK low -> SDA is high-Z on the next clock; all outputs 0; the next START plus address transfer works normally.
